// File: rtl/alu_mon_pkg.sv
// rtl/alu_mon_pkg.sv - shared indices, state type and command classification for the ALU monitor
package alu_mon_pkg;

    localparam int VIOL_CE_HOLD = 0;
    localparam int VIOL_TIMEOUT = 1;
    localparam int VIOL_CMD_CHG = 2;
    localparam int VIOL_RST_OUT = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } pair_state_e;

    // Commands whose result depends on both opa and opb; cmd is zero-extended by the caller.
    function automatic logic needs_both(input logic mode, input logic [31:0] cmd);
        if (mode)
            return cmd inside {32'd0, 32'd1, 32'd2, 32'd3, 32'd8, 32'd9, 32'd10};
        else
            return cmd inside {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd12, 32'd13};
    endfunction

endpackage

// File: rtl/alu_mon_pair_fsm.sv
// rtl/alu_mon_pair_fsm.sv - split-operand pairing tracker with timeout and command-stability check
module alu_mon_pair_fsm
    import alu_mon_pkg::*;
#(
    parameter int CMD_WIDTH   = 4,
    parameter int WAIT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 mode,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [1:0]           inp_valid,
    output logic [1:0]           pair_viol,
    output logic                 pair_busy
);

    localparam logic [7:0] TIMER_LAST = 8'(WAIT_CYCLES - 1);

    pair_state_e          state, state_next;
    logic [CMD_WIDTH-1:0] cap_cmd, cap_cmd_next;
    logic                 cap_mode, cap_mode_next;
    logic [1:0]           got, got_next;
    logic [7:0]           timer, timer_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cap_cmd  <= '0;
            cap_mode <= 1'b0;
            got      <= 2'b00;
            timer    <= 8'd0;
        end else begin
            state    <= state_next;
            cap_cmd  <= cap_cmd_next;
            cap_mode <= cap_mode_next;
            got      <= got_next;
            timer    <= timer_next;
        end
    end

    // pair_viol[0] = timeout, pair_viol[1] = command changed while pending
    always_comb begin
        state_next    = state;
        cap_cmd_next  = cap_cmd;
        cap_mode_next = cap_mode;
        got_next      = got;
        timer_next    = timer;
        pair_viol     = 2'b00;
        case (state)
            ST_IDLE: begin
                if (ce && needs_both(mode, 32'(cmd)) &&
                    (inp_valid == 2'b01 || inp_valid == 2'b10)) begin
                    state_next    = ST_WAIT;
                    cap_cmd_next  = cmd;
                    cap_mode_next = mode;
                    got_next      = inp_valid;
                    timer_next    = 8'd0;
                end
            end
            ST_WAIT: begin
                if (ce) begin
                    timer_next = timer + 8'd1;
                    if (cmd != cap_cmd || mode != cap_mode) begin
                        pair_viol[1] = 1'b1;
                        state_next   = ST_IDLE;
                    end else if ((inp_valid | got) == 2'b11) begin
                        state_next = ST_IDLE;
                    end else if (timer == TIMER_LAST) begin
                        pair_viol[0] = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        got_next = got | inp_valid;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pair_busy = (state == ST_WAIT);

endmodule

// File: rtl/alu_protocol_monitor.sv
// rtl/alu_protocol_monitor.sv - passive ALU bus checker with sticky, counted and first-captured violations
module alu_protocol_monitor
    import alu_mon_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CMD_WIDTH    = 4,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
    parameter int WAIT_CYCLES  = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    ce,
    input  logic                    mode,
    input  logic [CMD_WIDTH-1:0]    cmd,
    input  logic [1:0]              inp_valid,
    input  logic [DATA_WIDTH-1:0]   opa,
    input  logic [DATA_WIDTH-1:0]   opb,
    input  logic [RESULT_WIDTH-1:0] res,
    input  logic                    cout,
    input  logic                    oflow,
    input  logic                    g,
    input  logic                    l,
    input  logic                    e,
    input  logic                    err,
    output logic [3:0]              viol,
    output logic [3:0]              viol_sticky,
    output logic [CNT_WIDTH-1:0]    viol_count,
    output logic [1:0]              first_viol_code,
    output logic                    first_viol_valid,
    output logic                    pair_busy
);

    localparam int O_W   = RESULT_WIDTH + 6;
    localparam int SUM_W = CNT_WIDTH + 3;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

    logic [O_W-1:0]   o_cur, o_d;
    logic             ce_d, rst_d;
    logic [1:0]       pair_viol;
    logic [3:0]       viol_next;
    logic [2:0]       viol_pop;
    logic [SUM_W-1:0] count_sum;
    logic [1:0]       first_code_next;

    // Operands are observed on the bus but no rule depends on their values.
    logic unused_operands;
    assign unused_operands = ^{opa, opb};

    assign o_cur = {res, cout, oflow, g, l, e, err};

    alu_mon_pair_fsm #(
        .CMD_WIDTH   (CMD_WIDTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_pair_fsm (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .mode      (mode),
        .cmd       (cmd),
        .inp_valid (inp_valid),
        .pair_viol (pair_viol),
        .pair_busy (pair_busy)
    );

    // The hold check is skipped right after reset: o_d holds no real DUT output yet.
    always_comb begin
        viol_next               = 4'b0000;
        viol_next[VIOL_CE_HOLD] = !rst_d && !ce_d && (o_cur != o_d);
        viol_next[VIOL_TIMEOUT] = pair_viol[0];
        viol_next[VIOL_CMD_CHG] = pair_viol[1];
        viol_next[VIOL_RST_OUT] = rst_d && (|o_cur);
    end

    assign viol_pop  = {2'b00, viol_next[0]} + {2'b00, viol_next[1]} +
                       {2'b00, viol_next[2]} + {2'b00, viol_next[3]};
    assign count_sum = SUM_W'(viol_count) + SUM_W'(viol_pop);

    always_comb begin
        first_code_next = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (viol_next[i]) first_code_next = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rst_d            <= 1'b1;
            o_d              <= '0;
            ce_d             <= 1'b0;
            viol             <= 4'b0000;
            viol_sticky      <= 4'b0000;
            viol_count       <= '0;
            first_viol_code  <= 2'd0;
            first_viol_valid <= 1'b0;
        end else begin
            rst_d <= 1'b0;
            o_d   <= o_cur;
            ce_d  <= ce;
            viol  <= viol_next;
            if (clr) begin
                viol_sticky      <= 4'b0000;
                viol_count       <= '0;
                first_viol_code  <= 2'd0;
                first_viol_valid <= 1'b0;
            end else begin
                viol_sticky <= viol_sticky | viol_next;
                viol_count  <= (count_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}}
                                                     : count_sum[CNT_WIDTH-1:0];
                if (!first_viol_valid && (|viol_next)) begin
                    first_viol_code  <= first_code_next;
                    first_viol_valid <= 1'b1;
                end
            end
        end
    end

endmodule
